dma_avmm_master_arbiter: RTL

//  Shares the single DMA descriptor AVMM master between two requesters: the descriptor

---
 rtl/dma_avmm_master_arbiter_if.sv | 48 ++++
 rtl/dma_avmm_master_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/dma_avmm_master_arbiter_if.sv
// Bundle of requester-side and fabric-side signals around the DMA descriptor AVMM master.
// Latency: none, wires only.
// Backpressure: carries the per-requester wait requests and the fabric waitrequest.
// Ports: master = arbiter side; slave = requesters plus fabric (environment side).
interface dma_avmm_master_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch engine (read requester)
  logic                rd_req_i;
  logic [ADDR_W-1:0]   rd_addr_i;
  logic                rd_wait_req_o;
  logic [DATA_W-1:0]   rd_data_o;
  logic                rd_data_valid_o;
  // status-update engine (write requester)
  logic                wr_req_i;
  logic [ADDR_W-1:0]   wr_addr_i;
  logic [DATA_W-1:0]   wr_data_i;
  logic [DATA_W/8-1:0] wr_be_i;
  logic                wr_wait_req_o;
  // fabric master port
  logic [ADDR_W-1:0]   avm_address_o;
  logic                avm_read_o;
  logic                avm_write_o;
  logic [DATA_W-1:0]   avm_writedata_o;
  logic [DATA_W/8-1:0] avm_byteenable_o;
  logic                avm_waitrequest_i;
  logic [DATA_W-1:0]   avm_readdata_i;
  logic                avm_readdatavalid_i;
  // debug / CSR
  logic [3:0]          pend_rd_o;

  modport master (
    input  rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i, wr_be_i,
           avm_waitrequest_i, avm_readdata_i, avm_readdatavalid_i,
    output rd_wait_req_o, rd_data_o, rd_data_valid_o, wr_wait_req_o,
           avm_address_o, avm_read_o, avm_write_o, avm_writedata_o, avm_byteenable_o,
           pend_rd_o
  );

  modport slave (
    output rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i, wr_be_i,
           avm_waitrequest_i, avm_readdata_i, avm_readdatavalid_i,
    input  rd_wait_req_o, rd_data_o, rd_data_valid_o, wr_wait_req_o,
           avm_address_o, avm_read_o, avm_write_o, avm_writedata_o, avm_byteenable_o,
           pend_rd_o
  );
endinterface

// File: rtl/dma_avmm_master_arbiter.sv
// Round-robin share of one AVMM master between descriptor fetch (reads) and status write-back.
// Latency: 1 ARB cycle then the grant cycle(s); read data forwarded combinationally.
// Backpressure: ungranted requester sees wait_req=1; granted one sees fabric waitrequest.
// Ports: clk, reset_n (sync, active low), bus (master modport of dma_avmm_master_arbiter_if).
module dma_avmm_master_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_PEND_RD = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  dma_avmm_master_arbiter_if.master   bus
);
  localparam logic [3:0] MAX_P = 4'(MAX_PEND_RD);

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    GNT_WR = 2'd1,
    GNT_RD = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                last_grant_wr;   // 0 = last grant went to the read side
  logic [3:0]          pend_rd;
  logic                rd_eligible;
  logic                rd_accept;

  logic                avm_read, avm_write;
  logic [ADDR_W-1:0]   avm_address;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                rd_wait_req, wr_wait_req;

  // A read is only considered once there is room for another response.
  assign rd_eligible = bus.rd_req_i && (pend_rd < MAX_P);
  assign rd_accept   = (state == GNT_RD) && !bus.avm_waitrequest_i;

  always_comb begin
    state_nxt      = state;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    avm_byteenable = '0;
    rd_wait_req    = 1'b1;
    wr_wait_req    = 1'b1;
    case (state)
      ARB: begin
        if (bus.wr_req_i && rd_eligible)
          state_nxt = last_grant_wr ? GNT_RD : GNT_WR;
        else if (bus.wr_req_i)
          state_nxt = GNT_WR;
        else if (rd_eligible)
          state_nxt = GNT_RD;
      end
      GNT_WR: begin
        avm_write      = 1'b1;
        avm_address    = bus.wr_addr_i;
        avm_writedata  = bus.wr_data_i;
        avm_byteenable = bus.wr_be_i;
        wr_wait_req    = bus.avm_waitrequest_i;
        if (!bus.avm_waitrequest_i)
          state_nxt = ARB;
      end
      GNT_RD: begin
        avm_read       = 1'b1;
        avm_address    = bus.rd_addr_i;
        avm_byteenable = '1;
        rd_wait_req    = bus.avm_waitrequest_i;
        if (!bus.avm_waitrequest_i)
          state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ARB;
      last_grant_wr <= 1'b0;
      pend_rd       <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == ARB && state_nxt == GNT_WR)
        last_grant_wr <= 1'b1;
      else if (state == ARB && state_nxt == GNT_RD)
        last_grant_wr <= 1'b0;
      // Accept and response together cancel; a stray response at 0 is ignored.
      case ({rd_accept, bus.avm_readdatavalid_i})
        2'b10:   pend_rd <= pend_rd + 4'd1;
        2'b01:   if (pend_rd != 4'd0) pend_rd <= pend_rd - 4'd1;
        default: pend_rd <= pend_rd;
      endcase
    end
  end

  assign bus.avm_read_o       = avm_read;
  assign bus.avm_write_o      = avm_write;
  assign bus.avm_address_o    = avm_address;
  assign bus.avm_writedata_o  = avm_writedata;
  assign bus.avm_byteenable_o = avm_byteenable;
  assign bus.rd_wait_req_o    = rd_wait_req;
  assign bus.wr_wait_req_o    = wr_wait_req;
  assign bus.rd_data_o        = bus.avm_readdata_i;
  assign bus.rd_data_valid_o  = bus.avm_readdatavalid_i;
  assign bus.pend_rd_o        = pend_rd;
endmodule
